lsu_unit: RTL
=============

# lsu_unit

Load/store unit between the pipeline's memory stage and port A of the dual-port data memory. It translates RV32 byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-addressed accesses with byte masks. Loads are sign- or zero-extended into a registered response. A misaligned access that crosses a word boundary is split into two consecutive memory cycles, and the upstream stage is stalled for the extra cycle.

## Interface
- ADDR_W, 16, word-address width driven to memory; byte address bits [ADDR_W+1:2] are used, and higher bits are ignored.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  1  request valid.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32 size/sign code.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_ready  out  1  unit can accept a request this cycle.
- o_mem_addr  out  ADDR_W  word address to memory port A.
- o_mem_wdata  out  32  lane-aligned write data.
- o_mem_bmask  out  4  byte-enable mask.
- o_mem_wren  out  1  write enable.
- i_mem_rdata  in  32  asynchronous read data from memory port A.
- o_rsp_valid  out  1  load/store completion pulse.
- o_rdata  out  32  extended load data; 0 for stores.
- o_err  out  1  illegal funct3 flag, valid with o_rsp_valid.

## Operation
- **Request handshake**
  - A request is accepted when i_req && o_ready.
  - o_ready = (state == IDLE).
  - While o_ready = 0, i_req is ignored and upstream must hold it.
- **States**
  - IDLE: drives memory combinationally from the inputs.
  - SECOND: drives memory from registered request fields.
- **Size and offset**
  - off = i_addr[1:0].
  - size mask: 0001 for funct3[1:0] = 00, 0011 for 01, 1111 for 10.
  - Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010.
  - Any other funct3: no memory write; o_rsp_valid = 1 next cycle with o_err = 1 and o_rdata = 0.
- **Split condition**
  - A request is split when (mask << off) has bits above bit 3.
  - Cases: word with off != 0, or half with off == 3.
- **First cycle** (IDLE, accepted request)
  - o_mem_addr = i_addr[ADDR_W+1:2].
  - o_mem_bmask = (mask << off)[3:0].
  - o_mem_wdata = i_wdata << 8*off.
  - o_mem_wren = i_we.
  - Load: i_mem_rdata is latched as w0.
- **Second cycle** (SECOND)
  - o_mem_addr = first address + 1, modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
  - o_mem_bmask = (mask << off)[7:4].
  - o_mem_wdata = i_wdata >> 8*(4-off).
  - o_mem_wren = stored i_we.
  - Load: the second word is taken as w1.
- **Load extraction**
  - raw = ({w1, w0} >> 8*off)[31:0]; w1 = 0 when the access is not split.
  - Byte/half are sign-extended for funct3[2] = 0 and zero-extended for funct3[2] = 1.
- **Idle outputs**: when no request is accepted and the unit is in IDLE, o_mem_wren = 0, o_mem_bmask = 0, o_mem_addr = 0, o_mem_wdata = 0.
- **Reset**
  - Forces IDLE at any point, including mid-split.
  - o_rsp_valid = 0, o_rdata = 0, o_err = 0, o_mem_wren = 0, o_mem_bmask = 0, o_ready = 1.
  - An interrupted split store may leave only its first part written; this is accepted.

## Timing
- Aligned or non-crossing access: accepted in cycle N; o_rsp_valid = 1 in cycle N+1 with o_rdata; o_ready stays 1.
- Split access:
  - Accepted in cycle N.
  - Cycle N+1: SECOND; o_ready = 0.
  - Cycle N+2: o_rsp_valid = 1.
  - A new request can be accepted in N+2.
- Back-to-back aligned requests are accepted on every cycle; o_rsp_valid pulses in each following cycle.
- o_rsp_valid, o_rdata and o_err are registered and held for exactly one cycle. o_rdata returns to 0 when o_rsp_valid = 0.
- Store data reaches memory at the same edge at which the memory captures it (the accept edge, or the SECOND-cycle edge for the second part).

## Test plan
- **SW then LW, aligned.** SW 0xDEADBEEF at 0x100, then LW at 0x100.
  - Store: bmask 1111, addr 0x40.
  - Load: o_rdata 0xDEADBEEF one cycle after accept.
- **Byte loads.** Memory word at 0x40 = 0x80FF7F01.
  - LB at 0x103 -> 0xFFFFFF80.
  - LBU at 0x103 -> 0x00000080.
  - LH at 0x102 -> 0xFFFF80FF.
- **Split LW.** Words 0x40 = 0x44332211 and 0x41 = 0x88776655; LW at 0x101.
  - o_ready = 0 for one cycle.
  - Addresses driven 0x40, then 0x41.
  - o_rdata = 0x55443322 two cycles after accept.
- **Split SH at word wrap.** SH 0xABCD at byte address 0x3FFFF.
  - Cycle 1: addr 0xFFFF, bmask 1000, wdata[31:24] = 0xCD.
  - Cycle 2: addr 0x0000, bmask 0001, wdata[7:0] = 0xAB.
- **Reset mid-split.** Assert i_reset during SECOND of a split SW.
  - Outputs immediately go to reset values, including o_mem_wren = 0.
  - After release, o_ready = 1 and an aligned LW completes normally.
- **Illegal funct3.** Load with funct3 = 011.
  - No write occurs.
  - o_rsp_valid = 1, o_err = 1, o_rdata = 0.
  - o_ready stays 1.

Source files
------------

// File: rtl/lsu_unit_if.sv
// lsu_unit_if
// Bundles the pipeline request/response handshake and the memory port A bus
// of the load/store unit.
//   slave  : the load/store unit (takes requests and read data, drives memory
//            and the response)
//   master : the surrounding pipeline and memory model
// Request : i_req, i_we, i_funct3, i_addr, i_wdata -> o_ready
// Memory  : o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren <- i_mem_rdata
// Response: o_rsp_valid, o_rdata, o_err
interface lsu_unit_if #(
  parameter int ADDR_W = 16
);
  logic              i_req;
  logic              i_we;
  logic [2:0]        i_funct3;
  logic [31:0]       i_addr;
  logic [31:0]       i_wdata;
  logic              o_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;
  logic              o_rsp_valid;
  logic [31:0]       o_rdata;
  logic              o_err;

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    output o_ready, o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren,
    output o_rsp_valid, o_rdata, o_err
  );

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    input  o_ready, o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren,
    input  o_rsp_valid, o_rdata, o_err
  );
endinterface

// File: rtl/lsu_unit.sv
// lsu_unit
// RV32 load/store unit in front of port A of the data memory. Byte-addressed
// LB/LH/LW/LBU/LHU/SB/SH/SW requests become word accesses with byte masks.
// An access whose bytes cross a word boundary takes a second memory cycle,
// during which o_ready is low. Load results are extended and registered.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : lsu_unit_if.slave (request, memory port A, response)
module lsu_unit #(
  parameter int ADDR_W = 16
) (
  input  logic     i_clk,
  input  logic     i_reset,
  lsu_unit_if.slave bus
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [2:0]        funct3_reg;
  logic [1:0]        off_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       w0_reg;
  logic [3:0]        mask_hi_reg;
  logic              rsp_valid_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;

  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic [7:0]        lane_mask;
  logic              legal;
  logic              accept;
  logic              split;
  logic [4:0]        sh_first;
  logic [5:0]        sh_second;
  logic [63:0]       pair_word;
  logic [31:0]       split_raw;
  logic [31:0]       single_raw;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_bmask;
  logic              mem_wren;

  assign off        = bus.i_addr[1:0];
  assign lane_mask  = {4'b0000, size_mask} << off;
  // Reset gates acceptance so memory sees no write while reset is held.
  assign accept     = bus.i_req && (state_reg == IDLE) && !i_reset;
  assign split      = legal && (lane_mask[7:4] != 4'b0000);
  assign sh_first   = {off, 3'b000};
  // Only reached with off_reg in 1..3, so the shift is 8..24.
  assign sh_second  = 6'd32 - {1'b0, off_reg, 3'b000};
  assign pair_word  = {bus.i_mem_rdata, w0_reg};
  assign split_raw  = pair_word[{off_reg, 3'b000} +: 32];
  assign single_raw = bus.i_mem_rdata >> sh_first;

  always_comb begin
    case (bus.i_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Zero/sign-extended sizes exist only for loads.
  always_comb begin
    case (bus.i_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.i_we;
      default:                legal = 1'b0;
    endcase
  end

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   extend = f3[2] ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   extend = f3[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  // Next state and memory port drive. IDLE is combinational from the request,
  // SECOND replays the registered request for the upper lanes.
  always_comb begin
    state_next = state_reg;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    mem_bmask  = 4'b0000;
    mem_wren   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && legal) begin
          mem_addr  = bus.i_addr[ADDR_W+1:2];
          mem_bmask = lane_mask[3:0];
          mem_wdata = bus.i_wdata << sh_first;
          mem_wren  = bus.i_we;
          if (split) begin
            state_next = SECOND;
          end
        end
      end
      SECOND: begin
        mem_addr   = addr_reg + ADDR_W'(1);
        mem_bmask  = mask_hi_reg;
        mem_wdata  = wdata_reg >> sh_second;
        mem_wren   = we_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request capture for the second cycle, and the one-cycle response pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      off_reg       <= 2'b00;
      wdata_reg     <= 32'h0;
      w0_reg        <= 32'h0;
      mask_hi_reg   <= 4'b0000;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= 32'h0;
      err_reg       <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= 32'h0;
      err_reg       <= 1'b0;
      if (state_reg == SECOND) begin
        rsp_valid_reg <= 1'b1;
        rdata_reg     <= we_reg ? 32'h0 : extend(split_raw, funct3_reg);
      end else if (accept) begin
        if (!legal) begin
          rsp_valid_reg <= 1'b1;
          err_reg       <= 1'b1;
        end else if (split) begin
          addr_reg    <= bus.i_addr[ADDR_W+1:2];
          we_reg      <= bus.i_we;
          funct3_reg  <= bus.i_funct3;
          off_reg     <= off;
          wdata_reg   <= bus.i_wdata;
          w0_reg      <= bus.i_mem_rdata;
          mask_hi_reg <= lane_mask[7:4];
        end else begin
          rsp_valid_reg <= 1'b1;
          rdata_reg     <= bus.i_we ? 32'h0 : extend(single_raw, bus.i_funct3);
        end
      end
    end
  end

  assign bus.o_ready     = (state_reg == IDLE);
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_bmask = mem_bmask;
  assign bus.o_mem_wren  = mem_wren;
  assign bus.o_rsp_valid = rsp_valid_reg;
  assign bus.o_rdata     = rdata_reg;
  assign bus.o_err       = err_reg;

endmodule
